// File: rtl/mac_pkg.sv
// mac_pkg
// Shared definitions for the psum drain / requantization path:
//   - state_e : drain controller states
//   - RND_*   : requantization rounding-mode encodings (round_mode port)
package mac_pkg;

  // Drain controller states
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,  // no job active
    ST_WAIT  = 2'd1,  // job active, holding register empty
    ST_DRAIN = 2'd2   // emitting write beats from the holding register
  } state_e;

  // Rounding modes applied before the arithmetic right shift
  localparam logic [1:0] RND_TRUNC     = 2'd0;  // floor
  localparam logic [1:0] RND_HALF_UP   = 2'd1;  // add 2^(s-1) then floor
  localparam logic [1:0] RND_HALF_EVEN = 2'd2;  // ties to even
  localparam logic [1:0] RND_TRUNC_ALT = 2'd3;  // reserved, behaves as floor

endpackage

// File: rtl/requant_lane.sv
// requant_lane
// One lane of requantization, purely combinational:
// arithmetic right shift with selectable rounding, then optional saturation.
// Ports:
//   psum_in      [PS_W-1:0]  signed partial sum
//   shift_amount [4:0]       right-shift distance (0 bypasses rounding)
//   round_mode   [1:0]       RND_* encoding from mac_pkg
//   sat_en                   1: clamp to signed OUT_W range, 0: keep low bits
//   q_out        [OUT_W-1:0] requantized value
//   sat_out                  lane was clamped
module requant_lane
  import mac_pkg::*;
#(
  parameter int PS_W  = 32,
  parameter int OUT_W = 8
) (
  input  logic [PS_W-1:0]  psum_in,
  input  logic [4:0]       shift_amount,
  input  logic [1:0]       round_mode,
  input  logic             sat_en,
  output logic [OUT_W-1:0] q_out,
  output logic             sat_out
);

  // Saturation bounds held at the widened PS_W+1 width
  localparam logic signed [PS_W:0] SAT_MAX = {{(PS_W+2-OUT_W){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [PS_W:0] SAT_MIN = {{(PS_W+2-OUT_W){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [PS_W:0] x_s;
  logic signed [PS_W:0] one_s;
  logic signed [PS_W:0] half_s;
  logic signed [PS_W:0] bias_s;
  logic signed [PS_W:0] sum_s;
  logic signed [PS_W:0] shr_s;
  logic        [PS_W:0] raw_sh_s;

  // Round, shift and saturate one lane; one extra bit keeps x + bias from overflowing
  always_comb begin
    x_s      = {psum_in[PS_W-1], psum_in};
    one_s    = {{PS_W{1'b0}}, 1'b1};
    half_s   = one_s << (shift_amount - 5'd1);
    // Bit 0 of the floor quotient decides ties for half-even
    raw_sh_s = x_s >> shift_amount;
    bias_s   = '0;
    q_out    = '0;
    sat_out  = 1'b0;

    if (shift_amount != 5'd0) begin
      case (round_mode)
        RND_HALF_UP:   bias_s = half_s;
        // half-1 rounds exact ties down; adding the quotient LSB pushes odd ties up
        RND_HALF_EVEN: bias_s = half_s - one_s + {{PS_W{1'b0}}, raw_sh_s[0]};
        RND_TRUNC,
        RND_TRUNC_ALT: bias_s = '0;
        default:       bias_s = '0;
      endcase
    end else begin
      bias_s = '0;
    end

    sum_s = x_s + bias_s;
    shr_s = sum_s >>> shift_amount;

    if (sat_en) begin
      if (shr_s > SAT_MAX) begin
        q_out   = SAT_MAX[OUT_W-1:0];
        sat_out = 1'b1;
      end else if (shr_s < SAT_MIN) begin
        q_out   = SAT_MIN[OUT_W-1:0];
        sat_out = 1'b1;
      end else begin
        q_out   = shr_s[OUT_W-1:0];
        sat_out = 1'b0;
      end
    end else begin
      q_out   = shr_s[OUT_W-1:0];
      sat_out = 1'b0;
    end
  end

endmodule

// File: rtl/psum_requant_drain.sv
// psum_requant_drain
// Accepts psum vectors from the array, requantizes them beat by beat and
// writes the beats to a buffer at consecutive addresses.
// Ports:
//   clk, rst_n (async active-low), clk_en (global enable / freeze)
//   start, num_vecs, base_addr              job launch
//   shift_amount, round_mode, sat_en        requant config, latched on start
//   psum_vec_out, psum_vld_out, psum_rdy_out  vector input handshake
//   wr_data, wr_addr, wr_vld, wr_rdy        buffer write beat handshake
//   busy, done (1-cycle pulse), sat_flag (sticky per job)
module psum_requant_drain
  import mac_pkg::*;
#(
  parameter int PS_W       = 32,
  parameter int OUT_W      = 8,
  parameter int LANES_OUT  = 256,
  parameter int BEAT_LANES = 32,
  parameter int ADDR_W     = 16
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        clk_en,
  input  logic                        start,
  input  logic [15:0]                 num_vecs,
  input  logic [ADDR_W-1:0]           base_addr,
  input  logic [4:0]                  shift_amount,
  input  logic [1:0]                  round_mode,
  input  logic                        sat_en,
  input  logic [LANES_OUT*PS_W-1:0]   psum_vec_out,
  input  logic                        psum_vld_out,
  output logic                        psum_rdy_out,
  output logic [BEAT_LANES*OUT_W-1:0] wr_data,
  output logic [ADDR_W-1:0]           wr_addr,
  output logic                        wr_vld,
  input  logic                        wr_rdy,
  output logic                        busy,
  output logic                        done,
  output logic                        sat_flag
);

  localparam int BEATS     = LANES_OUT / BEAT_LANES;
  localparam int BIDX_W    = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam int BEAT_BITS = BEAT_LANES * PS_W;
  localparam int WD_W      = BEAT_LANES * OUT_W;

  state_e                     state_q,    state_d;
  logic [15:0]                vec_rem_q,  vec_rem_d;
  logic [BIDX_W-1:0]          beat_idx_q, beat_idx_d;
  logic [ADDR_W-1:0]          addr_q,     addr_d;
  logic [4:0]                 shift_q,    shift_d;
  logic [1:0]                 mode_q,     mode_d;
  logic                       sat_en_q,   sat_en_d;
  logic [LANES_OUT*PS_W-1:0]  hold_q,     hold_d;
  logic [WD_W-1:0]            wr_data_q,  wr_data_d;
  logic [ADDR_W-1:0]          wr_addr_q,  wr_addr_d;
  logic                       wr_vld_q,   wr_vld_d;
  logic                       psum_rdy_q, psum_rdy_d;
  logic                       busy_q,     busy_d;
  logic                       done_q,     done_d;
  logic                       sat_flag_q, sat_flag_d;

  logic                       capture_s;
  logic                       wr_hs_s;
  logic                       last_beat_s;
  logic                       load_s;
  logic [BIDX_W-1:0]          sel_idx_s;
  logic [BEAT_BITS-1:0]       beat_src_s;
  logic [WD_W-1:0]            lane_q_s;
  logic [BEAT_LANES-1:0]      lane_sat_s;

  // Handshake decode and beat-source select, kept apart from the FSM so the
  // lane datapath does not loop back into the next-state block
  always_comb begin
    capture_s   = clk_en && (state_q == ST_WAIT) && psum_vld_out && psum_rdy_q;
    wr_hs_s     = clk_en && (state_q == ST_DRAIN) && wr_vld_q && wr_rdy;
    last_beat_s = (beat_idx_q == BIDX_W'(BEATS - 1));
    load_s      = capture_s || (wr_hs_s && !last_beat_s);
    if (capture_s) begin
      // Beat 0 comes straight off the input so it can be registered on the capture edge
      sel_idx_s  = '0;
      beat_src_s = psum_vec_out[BEAT_BITS-1:0];
    end else begin
      sel_idx_s  = beat_idx_q + BIDX_W'(1);
      beat_src_s = hold_q[int'(sel_idx_s)*BEAT_BITS +: BEAT_BITS];
    end
  end

  for (genvar g = 0; g < BEAT_LANES; g++) begin : g_lane
    requant_lane #(
      .PS_W  (PS_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .psum_in      (beat_src_s[g*PS_W +: PS_W]),
      .shift_amount (shift_q),
      .round_mode   (mode_q),
      .sat_en       (sat_en_q),
      .q_out        (lane_q_s[g*OUT_W +: OUT_W]),
      .sat_out      (lane_sat_s[g])
    );
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d    = state_q;
    vec_rem_d  = vec_rem_q;
    beat_idx_d = beat_idx_q;
    addr_d     = addr_q;
    shift_d    = shift_q;
    mode_d     = mode_q;
    sat_en_d   = sat_en_q;
    hold_d     = hold_q;
    wr_data_d  = wr_data_q;
    wr_addr_d  = wr_addr_q;
    wr_vld_d   = wr_vld_q;
    done_d     = done_q;
    sat_flag_d = sat_flag_q;

    if (clk_en) begin
      done_d = 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            shift_d    = shift_amount;
            mode_d     = round_mode;
            sat_en_d   = sat_en;
            addr_d     = base_addr;
            beat_idx_d = '0;
            sat_flag_d = 1'b0;
            vec_rem_d  = num_vecs;
            if (num_vecs == 16'd0) begin
              state_d = ST_IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            state_d = ST_IDLE;
          end
        end
        ST_WAIT: begin
          if (capture_s) begin
            hold_d     = psum_vec_out;
            beat_idx_d = '0;
            state_d    = ST_DRAIN;
          end else begin
            state_d = ST_WAIT;
          end
        end
        ST_DRAIN: begin
          if (wr_hs_s) begin
            if (last_beat_s) begin
              wr_vld_d   = 1'b0;
              beat_idx_d = '0;
              vec_rem_d  = vec_rem_q - 16'd1;
              if (vec_rem_q == 16'd1) begin
                state_d = ST_IDLE;
                done_d  = 1'b1;
              end else begin
                state_d = ST_WAIT;
              end
            end else begin
              beat_idx_d = sel_idx_s;
              state_d    = ST_DRAIN;
            end
          end else begin
            state_d = ST_DRAIN;
          end
        end
        default: begin
          state_d  = ST_IDLE;
          wr_vld_d = 1'b0;
        end
      endcase

      // Register a fresh beat and advance the running address
      if (load_s) begin
        wr_data_d = lane_q_s;
        wr_addr_d = addr_q;
        addr_d    = addr_q + ADDR_W'(1);
        wr_vld_d  = 1'b1;
        if (|lane_sat_s) begin
          sat_flag_d = 1'b1;
        end else begin
          sat_flag_d = sat_flag_d;
        end
      end else begin
        wr_data_d = wr_data_d;
      end
    end else begin
      state_d = state_q;
    end

    // Status outputs track the state being entered so they are registered
    psum_rdy_d = (state_d == ST_WAIT);
    busy_d     = (state_d != ST_IDLE);
  end

  // State and output registers with asynchronous clear
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      vec_rem_q  <= 16'd0;
      beat_idx_q <= '0;
      addr_q     <= '0;
      shift_q    <= 5'd0;
      mode_q     <= 2'd0;
      sat_en_q   <= 1'b0;
      hold_q     <= '0;
      wr_data_q  <= '0;
      wr_addr_q  <= '0;
      wr_vld_q   <= 1'b0;
      psum_rdy_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      sat_flag_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      vec_rem_q  <= vec_rem_d;
      beat_idx_q <= beat_idx_d;
      addr_q     <= addr_d;
      shift_q    <= shift_d;
      mode_q     <= mode_d;
      sat_en_q   <= sat_en_d;
      hold_q     <= hold_d;
      wr_data_q  <= wr_data_d;
      wr_addr_q  <= wr_addr_d;
      wr_vld_q   <= wr_vld_d;
      psum_rdy_q <= psum_rdy_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      sat_flag_q <= sat_flag_d;
    end
  end

  assign psum_rdy_out = psum_rdy_q;
  assign wr_data      = wr_data_q;
  assign wr_addr      = wr_addr_q;
  assign wr_vld       = wr_vld_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign sat_flag     = sat_flag_q;

endmodule
